// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage operand/result bundle between the pipeline and ex_muldiv.
// master = EX pipeline side, slave = multiply/divide unit.
interface ex_muldiv_if;
    localparam int unsigned XLEN = 32;

    logic            exception_flush;
    logic            ex_stall;
    logic            op_valid;
    logic [1:0]      op_sel;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            stall_req;
    logic            busy;
    logic            res_valid;
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;

    modport master (
        output exception_flush, ex_stall, op_valid, op_sel, src_a, src_b,
        input  stall_req, busy, res_valid, res_hi, res_lo
    );

    modport slave (
        input  exception_flush, ex_stall, op_valid, op_sel, src_a, src_b,
        output stall_req, busy, res_valid, res_hi, res_lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage.
// Single-cycle multiply, restoring radix-2 divide (32 iterations + sign fix).
// Optional macro MDU_DIV_ZERO_FAST_EN: divide by zero completes straight from IDLE.
module ex_muldiv (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 5;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e              state_q, state_d;
    logic                uns_q, uns_d;
    logic [XLEN-1:0]     a_q, a_d;        // multiplicand, or dividend/quotient shift register
    logic [XLEN-1:0]     b_q, b_d;        // multiplier, or |divisor|
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic [XLEN-1:0]     res_hi_q, res_hi_d;
    logic [XLEN-1:0]     res_lo_q, res_lo_d;

    logic                is_signed;
    logic [2*XLEN-1:0]   ext_a, ext_b, product;
    logic [XLEN:0]       rem_shift;
    logic                rem_ge;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        uns_d       = uns_q;
        a_d         = a_q;
        b_d         = b_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;

        is_signed   = !bus.op_sel[0];
        // Sign/zero extension to 64 bits makes one multiplier serve both MULT and MULTU
        ext_a       = uns_q ? {{XLEN{1'b0}}, a_q} : {{XLEN{a_q[XLEN-1]}}, a_q};
        ext_b       = uns_q ? {{XLEN{1'b0}}, b_q} : {{XLEN{b_q[XLEN-1]}}, b_q};
        product     = ext_a * ext_b;
        // 33-bit partial remainder: previous remainder shifted left with next dividend bit
        rem_shift   = {rem_q, a_q[XLEN-1]};
        rem_ge      = (rem_shift >= {1'b0, b_q});

        unique case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    uns_d = bus.op_sel[0];
                    if (!bus.op_sel[1]) begin
                        a_d     = bus.src_a;
                        b_d     = bus.src_b;
                        state_d = S_MUL;
                    end else begin
                        a_d       = (is_signed && bus.src_a[XLEN-1]) ? -bus.src_a : bus.src_a;
                        b_d       = (is_signed && bus.src_b[XLEN-1]) ? -bus.src_b : bus.src_b;
                        neg_quo_d = is_signed && (bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1]);
                        neg_rem_d = is_signed && bus.src_a[XLEN-1];
                        rem_d     = '0;
                        cnt_d     = '0;
                        state_d   = S_DIV;
`ifdef MDU_DIV_ZERO_FAST_EN
                        // Same values the iterative divider would produce for a zero divisor
                        if (bus.src_b == '0) begin
                            res_hi_d = bus.src_a;
                            res_lo_d = (is_signed && bus.src_a[XLEN-1]) ? XLEN'(1) : '1;
                            state_d  = S_DONE;
                        end
`endif
                    end
                end
            end
            S_MUL: begin
                res_hi_d = product[2*XLEN-1:XLEN];
                res_lo_d = product[XLEN-1:0];
                state_d  = S_DONE;
            end
            S_DIV: begin
                if (rem_ge) begin
                    rem_d = XLEN'(rem_shift - {1'b0, b_q});
                    a_d   = {a_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_lo_d = neg_quo_q ? -a_q : a_q;
                res_hi_d = neg_rem_q ? -rem_q : rem_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (!bus.ex_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything, including a same-cycle launch; no result is written
        if (bus.exception_flush) begin
            state_d  = S_IDLE;
            res_hi_d = res_hi_q;
            res_lo_d = res_lo_q;
        end

        res_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            uns_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
        end else begin
            state_q     <= state_d;
            uns_q       <= uns_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
        end
    end

    // Pipeline hold is combinational so the accept cycle itself stalls
    assign bus.stall_req = ((state_q == S_IDLE) && bus.op_valid) ||
                           (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_hi    = res_hi_q;
    assign bus.res_lo    = res_lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;
`ifdef MDU_DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 34;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ex_muldiv_if bus();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Launch one op at cycle 0, check stall window, latency and result
    task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int lat, input string name);
        int cyc;
        bit seen;
        bit stall_ok;
        next_cycle();
        bus.op_sel   = sel;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.op_valid = 1'b1;
        cyc      = 0;
        seen     = 1'b0;
        stall_ok = 1'b1;
        while (!seen && cyc <= lat + 4) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (cyc != lat) begin
                    n_bad++;
                    $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
                end
                n_cmp++;
                if (bus.res_hi !== exp_hi) begin
                    n_bad++;
                    $display("FAIL %s hi: got %h want %h", name, bus.res_hi, exp_hi);
                end
                n_cmp++;
                if (bus.res_lo !== exp_lo) begin
                    n_bad++;
                    $display("FAIL %s lo: got %h want %h", name, bus.res_lo, exp_lo);
                end
                n_cmp++;
                if (bus.stall_req !== 1'b0 || bus.busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s done_flags: stall_req=%b busy=%b want 0/1", name, bus.stall_req, bus.busy);
                end
            end else begin
                if (bus.stall_req !== 1'(cyc < lat)) stall_ok = 1'b0;
                next_cycle();
                cyc++;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s timeout: res_valid=0 after %0d cycles, want 1 at cycle %0d", name, cyc, lat);
        end
        n_cmp++;
        if (!stall_ok) begin
            n_bad++;
            $display("FAIL %s stall_window: stall_req not high exactly in cycles 0..%0d", name, lat - 1);
        end
        next_cycle();
        bus.op_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_done: res_valid=%b busy=%b want 0/0", name, bus.res_valid, bus.busy);
        end
    endtask

    task automatic check_idle_zero(input string name);
        n_cmp++;
        if (bus.stall_req !== 1'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.res_hi !== 32'h0 || bus.res_lo !== 32'h0) begin
            n_bad++;
            $display("FAIL %s: stall=%b busy=%b valid=%b hi=%h lo=%h want all 0", name,
                     bus.stall_req, bus.busy, bus.res_valid, bus.res_hi, bus.res_lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_idle_zero("reset_values");
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_mul();
        run_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT, "mult_neg");
        run_op(2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, MUL_LAT, "multu");
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MUL_LAT, "mult_m1sq");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT, "multu_maxsq");
    endtask

    task automatic test_div();
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, "div_m7_2");
        run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT, "div_7_m2");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT, "div_ovf");
        run_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT, "divu_100_7");
        run_op(2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DIV_LAT, "divu_big");
        run_op(2'b10, 32'hFFFFFFFF, 32'h00000010, 32'hFFFFFFFF, 32'h00000000, DIV_LAT, "div_m1_16");
    endtask

    task automatic test_div_zero();
        run_op(2'b11, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, DZ_LAT, "divu_5_0");
        run_op(2'b10, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, DZ_LAT, "div_5_0");
        run_op(2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'h00000001, DZ_LAT, "div_m5_0");
    endtask

    task automatic test_flush();
        bit quiet;
        next_cycle();
        bus.op_sel   = 2'b10;
        bus.src_a    = 32'd100;
        bus.src_b    = 32'd7;
        bus.op_valid = 1'b1;
        repeat (10) next_cycle();
        bus.exception_flush = 1'b1;
        bus.op_valid        = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_busy_before: got %b want 1", bus.busy);
        end
        next_cycle();
        bus.exception_flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0 || bus.res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle: busy=%b stall=%b valid=%b want 0/0/0", bus.busy, bus.stall_req, bus.res_valid);
        end
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL flush_no_result: res_valid or busy rose after flush, want stay 0");
        end
        // Flush in IDLE beats a same-cycle launch
        next_cycle();
        bus.op_sel          = 2'b00;
        bus.src_a           = 32'd3;
        bus.src_b           = 32'd4;
        bus.op_valid        = 1'b1;
        bus.exception_flush = 1'b1;
        next_cycle();
        bus.op_valid        = 1'b0;
        bus.exception_flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_vs_launch_busy: got %b want 0", bus.busy);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_vs_launch_valid: got %b want 0", bus.res_valid);
        end
    endtask

    task automatic test_ex_stall();
        bit held_ok;
        next_cycle();
        bus.op_sel   = 2'b00;
        bus.src_a    = 32'd6;
        bus.src_b    = 32'd7;
        bus.op_valid = 1'b1;
        next_cycle();
        next_cycle();
        bus.ex_stall = 1'b1;
        held_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_hi !== 32'd0 || bus.res_lo !== 32'd42 ||
                bus.stall_req !== 1'b0) held_ok = 1'b0;
            next_cycle();
            if (i == 2) bus.ex_stall = 1'b0;
        end
        n_cmp++;
        if (!held_ok) begin
            n_bad++;
            $display("FAIL stall_hold: result not held 4 cycles as 0/42 with stall_req 0");
        end
        // Cycle 6: back in IDLE, the next MULT is accepted immediately
        bus.src_a = 32'h00010000;
        bus.src_b = 32'h00010000;
        @(negedge clk);
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.stall_req !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_exit: valid=%b busy=%b stall=%b want 0/0/1", bus.res_valid, bus.busy, bus.stall_req);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: busy=%b valid=%b want 1/0", bus.busy, bus.res_valid);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus.res_valid !== 1'b1 || bus.res_hi !== 32'd1 || bus.res_lo !== 32'd0) begin
            n_bad++;
            $display("FAIL b2b_result: valid=%b hi=%h lo=%h want 1/00000001/00000000",
                     bus.res_valid, bus.res_hi, bus.res_lo);
        end
        next_cycle();
        bus.op_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        bus.op_sel   = 2'b10;
        bus.src_a    = 32'd1000;
        bus.src_b    = 32'd3;
        bus.op_valid = 1'b1;
        repeat (5) next_cycle();
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_mid_op");
    endtask

    initial begin
        rst                 = 1'b1;
        bus.exception_flush = 1'b0;
        bus.ex_stall        = 1'b0;
        bus.op_valid        = 1'b0;
        bus.op_sel          = 2'b00;
        bus.src_a           = 32'h0;
        bus.src_b           = 32'h0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_flush();
        test_ex_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
